// File: rtl/dmux_pkg.sv
// rtl/dmux_pkg.sv - shared widths and line encodings for the 4-way stream demux
package dmux_pkg;

  localparam int NUM_WAYS = 4;
  localparam int LINE_W   = 2;

  typedef logic [LINE_W-1:0] line_t;

  localparam line_t LINE_OUT1 = 2'b00;
  localparam line_t LINE_OUT2 = 2'b01;
  localparam line_t LINE_OUT3 = 2'b10;
  localparam line_t LINE_OUT4 = 2'b11;

endpackage

// File: rtl/dmux_slot.sv
// rtl/dmux_slot.sv - one-entry output holding slot with load/drain handshake
module dmux_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q,  vld_d;

  // Load wins over drain so a full slot can be refilled on the edge it empties.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (vld_q && ready_i) begin
      vld_d = 1'b0;
    end
    if (load_i) begin
      data_d = data_i;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = vld_q;

endmodule

// File: rtl/dmux4way16_stream.sv
// rtl/dmux4way16_stream.sv - registered 1-to-4 word demux with per-output holding slots
// Optional accepted-word counter port `count` when DMUX_COUNT_EN is defined.
module dmux4way16_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16
) (
`ifdef DMUX_COUNT_EN
  output logic [15:0]      count,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inp,
  input  line_t            line,
  input  logic             inp_valid,
  output logic             inp_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic             out_valid3,
  output logic             out_valid4,
  input  logic             out_ready1,
  input  logic             out_ready2,
  input  logic             out_ready3,
  input  logic             out_ready4
);

  logic [NUM_WAYS-1:0] vld;
  logic [NUM_WAYS-1:0] rdy;
  logic [NUM_WAYS-1:0] load;
  logic [WIDTH-1:0]    data [NUM_WAYS];
  logic                accept;

  assign rdy = {out_ready4, out_ready3, out_ready2, out_ready1};

  // Backpressure looks only at the addressed slot, so a stalled consumer blocks only its own words.
  assign inp_ready = rst_n & (~vld[line] | rdy[line]);
  assign accept    = inp_valid & inp_ready;

  for (genvar k = 0; k < NUM_WAYS; k++) begin : g_slot
    assign load[k] = accept & (line == line_t'(k));

    dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[k]),
      .data_i  (inp),
      .ready_i (rdy[k]),
      .data_o  (data[k]),
      .valid_o (vld[k])
    );
  end

  assign out1 = data[0];
  assign out2 = data[1];
  assign out3 = data[2];
  assign out4 = data[3];

  assign {out_valid4, out_valid3, out_valid2, out_valid1} = vld;

`ifdef DMUX_COUNT_EN
  logic [15:0] count_q, count_d;

  assign count_d = count_q + {15'd0, accept};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: doc/dmux4way16_stream.md
Name: dmux4way16_stream

Overview:
- Registered 1-to-4 demultiplexer for 16-bit words, with a valid/ready handshake on the input and on each output.
- Performs the inverse of the 4-way read mux: a single producer, such as a writeback or bus-write path, steers each word to one of four consumers selected by `line`.
- Each output has a one-entry holding slot, so one consumer stalling never blocks words headed to the other outputs.
- Sits between the datapath write port and the register, RAM and IO write ports.

Parameters:
- WIDTH, 16, data width of `inp` and of `out1`..`out4`.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous reset, active-low.
- inp  input  WIDTH  word to route.
- line  input  2  destination select: 00→out1, 01→out2, 10→out3, 11→out4.
- inp_valid  input  1  `inp` and `line` are valid.
- inp_ready  output  1  word will be accepted at the next rising edge.
- out1..out4  output  WIDTH each  slot data.
- out_valid1..out_valid4  output  1 each  slot holds a word.
- out_ready1..out_ready4  input  1 each  consumer takes the word.

Behaviour:
- Reset: clk single clock domain. When rst_n=0, asynchronously clear all out_validK=0 and all outK=0. inp_ready=0 while rst_n=0.
- Per-slot state: register `data_k` and flag `vld_k`, with outK=data_k and out_validK=vld_k (registered, no combinational path from inp).
- inp_ready is combinational: rst_n & (~vld[line] | out_ready[line]). It depends only on the selected slot.
- Accept: inp_valid & inp_ready at a rising edge → data[line]<=inp, vld[line]<=1. Word appears on outK the next cycle (latency 1).
- Drain: vld_k & out_readyK at an edge → vld_k<=0, unless the same edge loads slot k.
- Simultaneous drain and load on one slot: new word is loaded and vld stays 1, giving full throughput of 1 word/cycle into one output.
- Non-selected slots are unaffected by input activity. Any mix of outputs may drain on the same edge.
- While vld_k & ~out_readyK, outK is held stable. While inp_valid & ~inp_ready, the producer holds inp and line.
- Ordering is preserved per destination. There is no ordering guarantee across destinations.
- inp_valid=0: nothing loads. `line` and `inp` are don't-care.
- Reset mid-operation: pending words are discarded, and no partial transfer is visible after release.
- First accept is possible at the first rising edge after rst_n deasserts.

Optional Feature:
- Macro DMUX_COUNT_EN.
- Defined: adds output `count` [15:0], incremented by 1 on every accepted input word. Reset value is 0. It wraps from 16'hFFFF to 0 and is readable combinationally from the register.
- Undefined: no `count` port and no counter logic. Routing behaviour is identical in both builds.

Decomposition:
- Shared package `dmux_pkg`:
  - NUM_WAYS=4
  - LINE_W=2
  - line typedef `line_t`
  - line encodings LINE_OUT1..LINE_OUT4
- Sub-module `dmux_slot`: one holding register plus valid flag, with load/drain logic. Instantiated 4×, with `load` = inp_valid & inp_ready & (line==k).

Test Plan:
- Reset, then a single word per way: inp=16'h5555 with line=00..11 in sequence, all out_ready=1 → each value appears on the matching outK one cycle after accept, with only that out_validK high, for one cycle.
- Stall: out_ready2=0, send 16'hFFFF to line=01, then 16'h00FF to line=01 → second word sees inp_ready=0 and out2 holds FFFF. Raising out_ready2 accepts 00FF on the same edge, and out2=00FF the next cycle.
- Independence: out_ready1=0 with slot1 full; send 16'h0000 to line=10 → accepted immediately and delivered on out3 while out1 is unchanged.
- Throughput: 8 back-to-back words 16'h0001..16'h0008 to line=11 with out_ready4=1 → inp_ready stays 1 and out4 shows 1..8 on consecutive cycles.
- Mid-operation reset: fill all four slots with out_ready=0, pulse rst_n low between edges → all out_validK and outK drop to 0 immediately, and inp_ready=0 while rst_n=0.
- DMUX_COUNT_EN build: preload the counter path by accepting 65537 words → count=1, confirming wrap.
